// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the CONV accelerator layer stages.
// Memory select codes route the time-shared scratch port to L0 or L1.
package conv_pkg;
    localparam int DW    = 20;
    localparam int IMG_W = 64;
    localparam int AW    = 12;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, WR, FIN} state_t;
endpackage

// File: rtl/maxpool_addr_gen.sv
// Output-window counters and L0/L1 address generation for the 2x2 max-pool stage.
// Addresses come from bit concatenation because IMG_W is a power of two.
module maxpool_addr_gen #(
    parameter int IMG_W = 64,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          step,
    input  logic [1:0]    sel,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] wr_addr,
    output logic          last
);
    import conv_pkg::*;

    localparam int OW = $clog2(IMG_W / 2);
    localparam logic [OW-1:0] OMAX = OW'(IMG_W / 2 - 1);

    logic [OW-1:0] ox;
    logic [OW-1:0] oy;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ox <= '0;
            oy <= '0;
        end else if (step) begin
            if (ox == OMAX) begin
                ox <= '0;
                oy <= oy + 1'b1;
            end else begin
                ox <= ox + 1'b1;
            end
        end
    end

    // {oy,dy,ox,dx} is (2*oy+dy)*IMG_W + 2*ox+dx; sel = {dy,dx}
    assign rd_addr = AW'({oy, sel[1], ox, sel[0]});
    assign wr_addr = AW'({oy, ox});
    assign last    = (ox == OMAX) && (oy == OMAX);
endmodule

// File: rtl/maxpool2x2_engine.sv
// Layer-1 stage: reads the 64x64 L0 map, writes the max of each 2x2 window to L1.
// Each output takes four read cycles and one write cycle; all outputs are registered.
module maxpool2x2_engine #(
    parameter int DW    = 20,
    parameter int IMG_W = 64,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);
    import conv_pkg::*;

    state_t               state;
    logic signed [DW-1:0] max_r;
    logic signed [DW-1:0] rd_data;
    logic signed [DW-1:0] max_next;
    logic                 last_r;
    logic [1:0]           sel;
    logic [AW-1:0]        rd_addr;
    logic [AW-1:0]        wr_addr;
    logic                 last;

    maxpool_addr_gen #(.IMG_W(IMG_W), .AW(AW)) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == IDLE && start),
        .step    (state == RD3),
        .sel     (sel),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr),
        .last    (last)
    );

    assign rd_data  = $signed(cdata_rd);
    assign max_next = (state == RD0 || rd_data > max_r) ? rd_data : max_r;

    // Window offset of the read issued on the coming edge
    always_comb begin
        sel = 2'd0;
        case (state)
            RD0:     sel = 2'd1;
            RD1:     sel = 2'd2;
            RD2:     sel = 2'd3;
            default: sel = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            csel     <= '0;
            max_r    <= '0;
            last_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RD0;
                        busy     <= 1'b1;
                        crd      <= 1'b1;
                        csel     <= CSEL_L0;
                        caddr_rd <= rd_addr;
                    end
                end
                RD0, RD1, RD2: begin
                    max_r    <= max_next;
                    caddr_rd <= rd_addr;
                    state    <= (state == RD0) ? RD1 : (state == RD1) ? RD2 : RD3;
                end
                RD3: begin
                    max_r    <= max_next;
                    cdata_wr <= max_next;
                    caddr_wr <= wr_addr;
                    last_r   <= last;
                    crd      <= 1'b0;
                    cwr      <= 1'b1;
                    csel     <= CSEL_L1;
                    state    <= WR;
                end
                WR: begin
                    cwr <= 1'b0;
                    if (last_r) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        csel  <= '0;
                    end else begin
                        state    <= RD0;
                        crd      <= 1'b1;
                        csel     <= CSEL_L0;
                        caddr_rd <= rd_addr;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    crd   <= 1'b0;
                    cwr   <= 1'b0;
                    csel  <= '0;
                end
            endcase
        end
    end
endmodule
